// File: rtl/ps_pkg.sv
// Shared definitions for the program-sequencer fetch stage.
package ps_pkg;

    // IR[31:27] value that tags a compute instruction
    localparam logic [4:0] CMPT_OP = 5'b00001;

    // Instruction-register field positions seen by the compute decoder
    localparam int unsigned OPC_MSB = 31;
    localparam int unsigned OPC_LSB = 27;
    localparam int unsigned FLT_BIT = 26;
    localparam int unsigned FLD_MSB = 25;
    localparam int unsigned FLD_LSB = 5;

    // Fetch FSM encoding
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } ps_state_e;

endpackage

// File: rtl/ps_ir_skid.sv
// One-entry holding buffer for a response that arrives while the IR is stalled.
module ps_ir_skid
    import ps_pkg::*;
#(
    parameter int unsigned AW = 16,
    parameter int unsigned IW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          unload,
    input  logic          flush,
    input  logic [IW-1:0] din,
    input  logic [AW-1:0] din_pc,
    output logic [IW-1:0] dout,
    output logic [AW-1:0] dout_pc,
    output logic          full
);

    logic [IW-1:0] data_q;
    logic [AW-1:0] pc_q;
    logic          full_q;

    // Capture on load; flush and unload both just mark the entry empty
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= '0;
            pc_q   <= '0;
            full_q <= 1'b0;
        end else if (flush) begin
            full_q <= 1'b0;
        end else if (load) begin
            data_q <= din;
            pc_q   <= din_pc;
            full_q <= 1'b1;
        end else if (unload) begin
            full_q <= 1'b0;
        end
    end

    assign dout    = data_q;
    assign dout_pc = pc_q;
    assign full    = full_q;

endmodule

// File: rtl/ps_fetch_ir.sv
// Fetch stage: issues program-memory reads, holds the IR and feeds the compute decoder.
module ps_fetch_ir #(
    parameter int unsigned   AW      = 16,
    parameter int unsigned   IW      = 32,
    parameter logic [AW-1:0] RST_PC  = '0,
    parameter logic [4:0]    CMPT_OP = ps_pkg::CMPT_OP
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          br_en,
    input  logic [AW-1:0] br_addr,
    output logic          ps_pm_rd_en,
    output logic [AW-1:0] ps_pm_addr,
    input  logic [IW-1:0] pm_ps_rdata,
    input  logic          pm_ps_rvalid,
    output logic [IW-1:0] ps_ir,
    output logic          ps_ir_vld,
    output logic [AW-1:0] ps_ir_pc,
    output logic          cpt_en,
    output logic          bt_26,
    output logic [20:0]   bt_5t25
);

    import ps_pkg::*;

    ps_state_e     state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] req_pc_q, req_pc_d;
    logic [IW-1:0] ir_q, ir_d;
    logic [AW-1:0] ir_pc_q, ir_pc_d;
    logic          ir_vld_q, ir_vld_d;
    logic          drop_q, drop_d;
    logic          rd_en;

    logic          skid_load, skid_unload, skid_flush;
    logic [IW-1:0] skid_data;
    logic [AW-1:0] skid_pc;
    logic          skid_full;

    ps_ir_skid #(
        .AW (AW),
        .IW (IW)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load    (skid_load),
        .unload  (skid_unload),
        .flush   (skid_flush),
        .din     (pm_ps_rdata),
        .din_pc  (req_pc_q),
        .dout    (skid_data),
        .dout_pc (skid_pc),
        .full    (skid_full)
    );

    // State, PC, IR and drop-flag registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= FETCH;
            pc_q     <= RST_PC;
            req_pc_q <= '0;
            ir_q     <= '0;
            ir_pc_q  <= '0;
            ir_vld_q <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            ir_q     <= ir_d;
            ir_pc_q  <= ir_pc_d;
            ir_vld_q <= ir_vld_d;
            drop_q   <= drop_d;
        end
    end

    // Next-state: fetch sequencing, IR load/consume, skid control, branch flush
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        ir_d        = ir_q;
        ir_pc_d     = ir_pc_q;
        drop_d      = drop_q;
        rd_en       = 1'b0;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        skid_flush  = 1'b0;
        // An unstalled edge consumes the IR unless something new loads below
        ir_vld_d    = stall ? ir_vld_q : 1'b0;

        unique case (state_q)
            FETCH: begin
                rd_en    = 1'b1;
                req_pc_d = pc_q;
                pc_d     = pc_q + AW'(1);
                state_d  = WAIT;
            end
            WAIT: begin
                if (pm_ps_rvalid) begin
                    state_d = FETCH;
                    if (drop_q) begin
                        drop_d = 1'b0;
                    end else if (!stall || !ir_vld_q) begin
                        ir_d     = pm_ps_rdata;
                        ir_pc_d  = req_pc_q;
                        ir_vld_d = 1'b1;
                    end else begin
                        skid_load = 1'b1;
                        state_d   = HOLD;
                    end
                end
            end
            HOLD: begin
                if (!stall) begin
                    ir_d        = skid_data;
                    ir_pc_d     = skid_pc;
                    ir_vld_d    = skid_full;
                    skid_unload = 1'b1;
                    state_d     = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        // Branch overrides everything: redirect, flush IR and skid
        if (br_en) begin
            pc_d       = br_addr;
            ir_d       = ir_q;
            ir_pc_d    = ir_pc_q;
            ir_vld_d   = 1'b0;
            skid_load  = 1'b0;
            skid_flush = 1'b1;
            rd_en      = 1'b0;
            if (state_q == WAIT && !pm_ps_rvalid) begin
                // Response still in flight: swallow it when it lands
                drop_d  = 1'b1;
                state_d = WAIT;
            end else begin
                drop_d  = 1'b0;
                state_d = FETCH;
            end
        end
    end

    // Request is masked while reset is held so every output reads 0 in reset
    assign ps_pm_rd_en = rd_en & rst;
    assign ps_pm_addr  = pc_q;

    assign ps_ir     = ir_q;
    assign ps_ir_vld = ir_vld_q;
    assign ps_ir_pc  = ir_pc_q;

    // Decoder taps; cpt_en is gated by stall so each instruction fires once
    assign cpt_en  = ir_vld_q & (ir_q[OPC_MSB:OPC_LSB] == CMPT_OP) & ~stall;
    assign bt_26   = ir_q[FLT_BIT];
    assign bt_5t25 = ir_q[FLD_MSB:FLD_LSB];

endmodule

// File: tb/tb_ps_fetch_ir.sv
// Self-checking bench for ps_fetch_ir: directed scenarios then randomized traffic.
module tb_ps_fetch_ir;

    import ps_pkg::*;

    localparam int unsigned AW     = 16;
    localparam int unsigned IW     = 32;
    localparam logic [15:0] RST_PC = 16'h0000;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          stall = 1'b0;
    logic          br_en = 1'b0;
    logic [15:0]   br_addr = '0;
    logic          ps_pm_rd_en;
    logic [15:0]   ps_pm_addr;
    logic [31:0]   pm_ps_rdata = '0;
    logic          pm_ps_rvalid = 1'b0;
    logic [31:0]   ps_ir;
    logic          ps_ir_vld;
    logic [15:0]   ps_ir_pc;
    logic          cpt_en;
    logic          bt_26;
    logic [20:0]   bt_5t25;

    ps_fetch_ir #(
        .AW      (AW),
        .IW      (IW),
        .RST_PC  (RST_PC),
        .CMPT_OP (5'b00001)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .br_en        (br_en),
        .br_addr      (br_addr),
        .ps_pm_rd_en  (ps_pm_rd_en),
        .ps_pm_addr   (ps_pm_addr),
        .pm_ps_rdata  (pm_ps_rdata),
        .pm_ps_rvalid (pm_ps_rvalid),
        .ps_ir        (ps_ir),
        .ps_ir_vld    (ps_ir_vld),
        .ps_ir_pc     (ps_ir_pc),
        .cpt_en       (cpt_en),
        .bt_26        (bt_26),
        .bt_5t25      (bt_5t25)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_pass = 0;
    int          n_issued = 0;
    // Memory model: one pending request, fixed latency chosen at request time
    int          lat = 1;
    int          cnt = 0;
    logic        busy = 1'b0;
    logic [15:0] mem_a = '0;
    // Program-order model: next expected request address and next issued pc
    logic [15:0] exp_req = RST_PC;
    logic [15:0] exp_iss = RST_PC;

    // Program memory contents
    function automatic logic [31:0] mem_word(input logic [15:0] a);
        logic [31:0] w;
        case (a)
            16'h0000: w = 32'h0800_1234;
            16'h0001: w = 32'hF800_0000;
            16'h0002: w = 32'h0C00_0FE0;
            default: begin
                w = {~a, a} ^ 32'h3C96_5A0F;
                if (a[1:0] == 2'b01) w[31:27] = CMPT_OP;
            end
        endcase
        return w;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock: check the cycle against the model, advance, then drive memory
    task automatic tick();
        logic        rq;
        logic [15:0] ra;
        logic        b;
        logic [15:0] ba;
        logic [31:0] w;
        #1;
        rq = ps_pm_rd_en;
        ra = ps_pm_addr;
        b  = br_en;
        ba = br_addr;
        if (b) check("no_req_on_branch", 64'(rq), 64'(0));
        if (rq) begin
            check("req_addr", 64'(ra), 64'(exp_req));
            check("one_outstanding", 64'(busy), 64'(0));
        end
        if (rst && ps_ir_vld && !stall) begin
            w = mem_word(exp_iss);
            check("issue_pc", 64'(ps_ir_pc), 64'(exp_iss));
            check("issue_ir", 64'(ps_ir), 64'(w));
            check("issue_cpt_en", 64'(cpt_en), 64'(w[31:27] == CMPT_OP));
            check("issue_bt_26", 64'(bt_26), 64'(w[26]));
            check("issue_bt_5t25", 64'(bt_5t25), 64'(w[25:5]));
            exp_iss = exp_iss + 16'd1;
            n_issued++;
        end else begin
            check("cpt_en_idle", 64'(cpt_en), 64'(0));
        end
        if (b) begin
            exp_req = ba;
            exp_iss = ba;
        end else if (rq) begin
            exp_req = ra + 16'd1;
        end
        @(posedge clk);
        #1;
        pm_ps_rvalid = 1'b0;
        if (!rst) begin
            busy = 1'b0;
        end else begin
            if (rq) begin
                busy  = 1'b1;
                cnt   = lat;
                mem_a = ra;
            end
            if (busy) begin
                cnt--;
                if (cnt == 0) begin
                    pm_ps_rvalid = 1'b1;
                    pm_ps_rdata  = mem_word(mem_a);
                    busy         = 1'b0;
                end
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_en"}, 64'(ps_pm_rd_en), 64'(0));
        check({tag, "_addr"}, 64'(ps_pm_addr), 64'(RST_PC));
        check({tag, "_ir"}, 64'(ps_ir), 64'(0));
        check({tag, "_ir_vld"}, 64'(ps_ir_vld), 64'(0));
        check({tag, "_ir_pc"}, 64'(ps_ir_pc), 64'(0));
        check({tag, "_cpt_en"}, 64'(cpt_en), 64'(0));
        check({tag, "_bt_26"}, 64'(bt_26), 64'(0));
        check({tag, "_bt_5t25"}, 64'(bt_5t25), 64'(0));
    endtask

    initial begin
        int iss_before;
        #2;
        check_reset_outputs("rst0");
        tick();
        tick();

        // Release: latency-1 fetch of a compute word at address 0
        rst = 1'b1;
        #1;
        check("c0_rd_en", 64'(ps_pm_rd_en), 64'(1));
        check("c0_addr", 64'(ps_pm_addr), 64'(16'h0000));
        tick();
        check("c1_rd_en", 64'(ps_pm_rd_en), 64'(0));
        tick();
        check("c2_vld", 64'(ps_ir_vld), 64'(1));
        check("c2_ir_pc", 64'(ps_ir_pc), 64'(16'h0000));
        check("c2_ir", 64'(ps_ir), 64'(32'h0800_1234));
        check("c2_cpt_en", 64'(cpt_en), 64'(1));
        check("c2_bt_26", 64'(bt_26), 64'(0));
        check("c2_bt_5t25", 64'(bt_5t25), 64'(21'h00_0091));
        check("c2_rd_en", 64'(ps_pm_rd_en), 64'(1));
        check("c2_addr", 64'(ps_pm_addr), 64'(16'h0001));
        tick();
        check("c3_vld", 64'(ps_ir_vld), 64'(0));
        tick();

        // Non-compute word still loads the IR
        check("c4_vld", 64'(ps_ir_vld), 64'(1));
        check("c4_ir", 64'(ps_ir), 64'(32'hF800_0000));
        check("c4_cpt_en", 64'(cpt_en), 64'(0));

        // Five stall cycles while the next response lands in the skid
        stall = 1'b1;
        tick();
        check("stall_ir_wait", 64'(ps_ir), 64'(32'hF800_0000));
        tick();
        for (int i = 0; i < 3; i++) begin
            check("stall_state_hold", 64'(dut.state_q), 64'(HOLD));
            check("stall_no_req", 64'(ps_pm_rd_en), 64'(0));
            check("stall_ir_hold", 64'(ps_ir), 64'(32'hF800_0000));
            check("stall_vld_hold", 64'(ps_ir_vld), 64'(1));
            check("stall_cpt_en", 64'(cpt_en), 64'(0));
            tick();
        end
        stall = 1'b0;
        #1;
        check("unstall_no_req", 64'(ps_pm_rd_en), 64'(0));
        tick();
        check("skid_ir", 64'(ps_ir), 64'(32'h0C00_0FE0));
        check("skid_ir_pc", 64'(ps_ir_pc), 64'(16'h0002));
        check("skid_cpt_en", 64'(cpt_en), 64'(1));
        check("skid_bt_26", 64'(bt_26), 64'(1));
        check("skid_bt_5t25", 64'(bt_5t25), 64'(21'h00_007F));
        check("skid_next_req", 64'(ps_pm_rd_en), 64'(1));
        check("skid_next_addr", 64'(ps_pm_addr), 64'(16'h0003));

        // Latency 4, branch in the second WAIT cycle
        lat = 4;
        tick();
        check("lat4_w1_vld", 64'(ps_ir_vld), 64'(0));
        tick();
        br_en   = 1'b1;
        br_addr = 16'h0040;
        tick();
        br_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("drop_vld", 64'(ps_ir_vld), 64'(0));
            check("drop_no_req", 64'(ps_pm_rd_en), 64'(0));
            tick();
        end
        lat = 1;
        check("drop_after_vld", 64'(ps_ir_vld), 64'(0));
        check("br_req", 64'(ps_pm_rd_en), 64'(1));
        check("br_addr", 64'(ps_pm_addr), 64'(16'h0040));
        tick();
        tick();
        check("br_ir_pc", 64'(ps_ir_pc), 64'(16'h0040));

        // PC wrap
        br_en   = 1'b1;
        br_addr = 16'hFFFF;
        tick();
        br_en = 1'b0;
        check("wrap_req", 64'(ps_pm_addr), 64'(16'hFFFF));
        tick();
        tick();
        check("wrap_next_addr", 64'(ps_pm_addr), 64'(16'h0000));
        check("wrap_ir_pc", 64'(ps_ir_pc), 64'(16'hFFFF));

        // Reset in WAIT, then a stale response right after release
        lat = 3;
        tick();
        rst = 1'b0;
        #1;
        check_reset_outputs("rst1");
        exp_req = RST_PC;
        exp_iss = RST_PC;
        tick();
        tick();
        rst          = 1'b1;
        pm_ps_rvalid = 1'b1;
        pm_ps_rdata  = 32'hDEAD_BEEF;
        lat          = 1;
        #1;
        check("rel_req", 64'(ps_pm_rd_en), 64'(1));
        check("rel_addr", 64'(ps_pm_addr), 64'(RST_PC));
        tick();
        check("stale_vld", 64'(ps_ir_vld), 64'(0));
        tick();
        check("stale_ir", 64'(ps_ir), 64'(32'h0800_1234));
        check("stale_ir_pc", 64'(ps_ir_pc), 64'(RST_PC));

        // Randomized traffic against the program-order model
        iss_before = n_issued;
        for (int i = 0; i < 600; i++) begin
            stall = ($urandom_range(0, 9) < 3);
            br_en = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0) br_addr = 16'hFFFC + 16'($urandom_range(0, 3));
            else br_addr = 16'($urandom);
            lat = int'($urandom_range(1, 4));
            tick();
        end
        br_en = 1'b0;
        stall = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("rand_progress", 64'((n_issued - iss_before) >= 40), 64'(1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ps_fetch_ir.md
Name: ps_fetch_ir

Overview:
- Program-sequencer fetch stage. Issues reads to program memory, holds the current instruction in the instruction register (IR), and drives the compute-instruction decoder directly downstream: cpt_en, bt_26, and instruction bits [25:5] as bt_5t25.
- Handles a variable-latency memory response, a downstream stall with a one-entry skid buffer, and a branch redirect that flushes the stage.

Parameters:
- AW, 16, program counter / program memory address width.
- IW, 32, instruction width; must be >= 32.
- RST_PC, 16'h0000, PC value after reset.
- CMPT_OP, 5'b00001, value of IR[31:27] that marks a compute instruction.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- stall  input  1  downstream hold; IR must not advance
- br_en  input  1  branch redirect strobe, single cycle
- br_addr  input  AW  branch target
- ps_pm_rd_en  output  1  program memory read request, one-cycle pulse
- ps_pm_addr  output  AW  read address, valid with ps_pm_rd_en
- pm_ps_rdata  input  IW  read data
- pm_ps_rvalid  input  1  read data valid, latency >= 1 cycle, one response per request
- ps_ir  output  IW  instruction register
- ps_ir_vld  output  1  IR holds an unissued instruction
- ps_ir_pc  output  AW  address of the instruction in IR
- cpt_en  output  1  ps_ir_vld & (ps_ir[31:27]==CMPT_OP) & ~stall
- bt_26  output  1  ps_ir[26]
- bt_5t25  output  21  ps_ir[25:5]

Behaviour:
- Reset (async, rst low):
  - state=FETCH, pc=RST_PC, ps_ir=0, ps_ir_pc=0, ps_ir_vld=0.
  - Skid buffer cleared, drop flag cleared.
  - All outputs are therefore 0, except ps_pm_addr=RST_PC.
  - Reset mid-transaction abandons any in-flight response: the drop flag is cleared, and a late rvalid arriving in FETCH is ignored.
- States: FETCH, WAIT, HOLD. A single outstanding request at most.
- FETCH:
  - ps_pm_rd_en=1, ps_pm_addr=pc.
  - Next edge: req_pc<=pc, pc<=pc+1 (wraps 2^AW-1 -> 0), go to WAIT.
- WAIT: ps_pm_rd_en=0. Nothing happens until pm_ps_rvalid. On rvalid:
  - drop=1: discard the data, clear drop, go to FETCH.
  - stall=0, or ps_ir_vld=0: ps_ir<=rdata, ps_ir_pc<=req_pc, ps_ir_vld<=1, go to FETCH.
  - stall=1 and ps_ir_vld=1: skid<=rdata, skid_pc<=req_pc, go to HOLD.
- HOLD:
  - No request is issued.
  - While stall=1, stay in HOLD.
  - When stall=0: ps_ir<=skid, ps_ir_pc<=skid_pc, ps_ir_vld<=1, go to FETCH.
- IR consumption:
  - On any edge with stall=0 where no new instruction loads, ps_ir_vld<=0. Each instruction is issued exactly once.
  - While stall=1, ps_ir, ps_ir_pc and ps_ir_vld hold.
- Branch (br_en=1) has priority over everything else:
  - pc<=br_addr, ps_ir_vld<=0, skid discarded.
  - From WAIT: set drop=1 and stay in WAIT.
  - From FETCH or HOLD: go to FETCH.
  - The FETCH request in the br_en cycle is suppressed (ps_pm_rd_en=0).
  - Branch with stall=1 still flushes.
  - Branch on the same edge as rvalid in WAIT discards that response (no drop needed), go to FETCH.
- Throughput: with 1-cycle memory latency, one instruction every 2 cycles.
- Output timing:
  - cpt_en, bt_26 and bt_5t25 are combinational from the IR, so the decoder sees the instruction in the cycle after the load edge.
  - cpt_en is gated by ~stall, so decoder register-file write enables never fire twice for one instruction.
  - bt_26 and bt_5t25 follow the IR even when cpt_en=0.

Decomposition:
- Shared package ps_pkg holds: CMPT_OP, the IR field positions (OPC_MSB=31, OPC_LSB=27, FLT_BIT=26, FLD_MSB=25, FLD_LSB=5), and the state encoding FETCH=2'd0, WAIT=2'd1, HOLD=2'd2.
- One sub-module is natural: ps_ir_skid, the one-entry data+pc holding buffer with load/unload/flush.
- The FSM and PC stay in the top level.

Test Plan:
- Reset release, memory latency 1, rdata=32'h0800_1234 at address 0:
  - -> rd_en at cycle 0 with addr 0.
  - -> ps_ir_vld=1 with ps_ir_pc=0.
  - -> cpt_en=1, bt_26=0, bt_5t25=21'h00_0091.
  - -> next request at addr 1.
- Non-compute word 32'hF800_0000 -> ps_ir_vld=1, cpt_en=0, IR still loaded.
- stall=1 held for 5 cycles while the response arrives:
  - -> state HOLD, ps_ir unchanged, no rd_en pulses, cpt_en=0.
  - -> stall drop loads the skid word; the next rd_en follows one cycle later.
- Memory latency 4, br_en with br_addr=16'h0040 in the 2nd WAIT cycle:
  - -> the late response is discarded and ps_ir_vld stays 0.
  - -> next rd_en addr=16'h0040.
- pc=16'hFFFF fetch -> following request addr=16'h0000 (wrap).
- rst asserted in WAIT, then released, then a stale rvalid:
  - -> the stale rvalid is ignored.
  - -> the first rd_en after release has addr=RST_PC.
  - -> all outputs are 0 during reset.
